fir_tdm_scheduler: RTL and testbench
====================================

// Module: fir_tdm_scheduler
// PURPOSE
//  Time-multiplexes one serial multiply-accumulate FIR datapath across CHANNELS sample streams.
//  - Round-robin arbitration picks a channel and accepts one sample with a valid/ready handshake.
//  - The block owns a per-channel delay line and steps the shared MAC one tap per cycle.
//  - It returns y = sum(coeff[k] * x[n-k]) tagged with the channel id.
//  - Coefficients come from a config write port. The block sits between the stream sources and the output sink.
// PARAMETERS
//  CHANNELS  4   number of requesting input streams (>=2)
//  ORDER     10  taps per filter (>=2)
//  DATA_W    32  sample/coeff/result width, signed two's complement
// PORTS
//  clk        in   1                clock
//  reset      in   1                synchronous, active-high
//  in_valid   in   CHANNELS         per-channel sample valid
//  in_data    in   CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
//  in_ready   out  CHANNELS         one-hot grant/accept; at most one bit high
//  out_valid  out  1                result valid
//  out_data   out  DATA_W           filter result
//  out_ch     out  $clog2(CHANNELS) channel that produced out_data
//  out_ready  in   1                sink accepts result
//  cfg_we     in   1                coefficient write strobe
//  cfg_addr   in   $clog2(ORDER)    tap index; >=ORDER is ignored
//  cfg_data   in   DATA_W           coefficient value
//  cfg_ready  out  1                high only in IDLE; write takes effect when cfg_we&&cfg_ready
//  busy       out  1                high in MAC or OUT
// BEHAVIOUR
//  Reset (sync, active-high):
//  - state=IDLE, rr_ptr=0, all delay lines=0, acc=0, tap=0.
//  - coeff[k] = fir_pkg::DEFAULT_COEFFS[k] = {10,3,2,1,-3,1,-3,-5,6,6}.
//  - Outputs: in_ready=0, out_valid=0, out_data=0, out_ch=0, cfg_ready=1 after reset, busy=0.
//  Reset mid-operation: the partial accumulation and the pending result are discarded. No output is produced for them.
//  States:
//  - IDLE: grant = first channel with in_valid, searching from rr_ptr upward with wrap. in_ready[grant]=1 (combinational).
//    - Handshake (in_valid&&in_ready): line[g][0]<=x, line[g][k]<=line[g][k-1]; store g; acc<=0; tap<=0; -> MAC.
//    - Other channels' lines never change.
//  - MAC: each cycle acc <= acc + coeff[tap]*line[g][tap]; tap++.
//    - Exits on the cycle tap==ORDER-1: out_data<=final sum, out_ch<=g -> OUT.
//  - OUT: out_valid=1, holding out_data/out_ch stable until out_ready.
//    - On out_ready: rr_ptr<=(g+1)%CHANNELS; -> IDLE.
//  Latency: sample handshake at cycle t -> out_valid first high at t+ORDER+1. Throughput is one result per ORDER+2 cycles minimum.
//  in_ready is 0 outside IDLE. in_valid outside IDLE is not consumed. Sources must hold data until accepted.
//  Arithmetic:
//  - Products are signed DATA_W x DATA_W, truncated to DATA_W LSBs.
//  - acc wraps modulo 2^DATA_W. No saturation.
//  - The result equals a direct-form convolution truncated to DATA_W.
//  Config:
//  - cfg_we in IDLE has priority over sample accept. in_ready is forced to 0 in that cycle.
//  - cfg_we outside IDLE is dropped, since cfg_ready=0.
//  - A coefficient write lands before the next accepted sample.
//  Boundaries:
//  - No requests: the block stays IDLE. rr_ptr is unchanged.
//  - All channels valid: channels are served ch0, ch1, ch2, ... in round-robin order, each once per round.
//  - out_ready held low: the block stalls in OUT indefinitely. No further samples are accepted.
//  - out_ready high on entry to OUT: one-cycle out_valid pulse.
//  - rr_ptr wrap: after CHANNELS-1 the next search starts at 0.
// STRUCTURE
//  Package fir_pkg:
//  - DATA_W, ORDER defaults and the DEFAULT_COEFFS array.
//  - typedef enum logic[1:0] {IDLE, MAC, OUT} fir_sched_state_t.
//  - typedef logic signed [DATA_W-1:0] sample_t.
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt and the encoded index.
//  - Purely combinational, with priority starting at ptr.
//  Delay lines are a CHANNELS x ORDER register array. Only the granted row shifts.
// TESTING
//  1 Reset defaults, ch0 impulse 1 then zeros -> outputs 10,3,2,1,-3,1,-3,-5,6,6,0; out_ch=0; each first valid 11 cycles after accept.
//  2 All 4 channels valid, out_ready=1 -> grants ch0,1,2,3,0,...; ch2's output is unaffected by samples on other channels.
//  3 out_ready low for 20 cycles in OUT -> out_valid/data/ch stable; all in_ready=0; no sample lost once released.
//  4 cfg write addr=0 data=-7 coincident with in_valid in IDLE -> in_ready=0 that cycle; next impulse yields -7 first.
//    cfg_we during MAC -> coefficient unchanged.
//  5 ch1 samples 0x7FFFFFFF,0x7FFFFFFF with coeff 10 -> out_data equals modulo-2^32 sum.
//    Reset asserted during MAC -> no out_valid; next impulse is computed on a zeroed delay line.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and reset-time defaults for the TDM FIR scheduler.
package fir_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ORDER  = 10;
    localparam int unsigned DEFAULT_AW     = $clog2(DEFAULT_ORDER);

    localparam int DEFAULT_COEFFS [DEFAULT_ORDER] = '{10, 3, 2, 1, -3, 1, -3, -5, 6, 6};

    typedef enum logic [1:0] {IDLE, MAC, OUT} fir_sched_state_t;

    typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

    // Reset value of tap k; taps beyond the default table start at zero.
    function automatic sample_t default_coeff(input int unsigned k);
        sample_t c;
        c = '0;
        for (int unsigned i = 0; i < DEFAULT_ORDER; i++) begin
            if (i == k) c = sample_t'(DEFAULT_COEFFS[DEFAULT_AW'(i)]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr) + i) % N;
            if (!found && req[IW'(cand)]) begin
                found           = 1'b1;
                gnt[IW'(cand)]  = 1'b1;
                idx             = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Shares one serial MAC across CHANNELS sample streams, one tap per cycle,
// with per-channel delay lines and a writable coefficient table.
module fir_tdm_scheduler
    import fir_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ORDER    = DEFAULT_ORDER,
    parameter int unsigned DATA_W   = DEFAULT_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(CHANNELS)-1:0]  out_ch,
    input  logic                         out_ready,
    input  logic                         cfg_we,
    input  logic [$clog2(ORDER)-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]            cfg_data,
    output logic                         cfg_ready,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(CHANNELS);
    localparam int unsigned TW = $clog2(ORDER);

    typedef logic signed [DATA_W-1:0] word_t;

    fir_sched_state_t state, state_nxt;

    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     cur_ch;
    logic [TW-1:0]     tap;
    logic [DATA_W-1:0] acc;
    word_t             line  [CHANNELS][ORDER];
    word_t             coeff [ORDER];

    logic [CHANNELS-1:0] gnt;
    logic [CW-1:0]       gnt_idx;
    logic                accept;
    logic                cfg_write;
    logic                last_tap;
    logic [DATA_W-1:0]   product;
    logic [DATA_W-1:0]   mac_sum;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .req (in_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign accept    = |(in_ready & in_valid);
    assign cfg_write = cfg_we && (state == IDLE);
    assign last_tap  = (tap == TW'(ORDER - 1));
    assign product   = coeff[tap] * line[cur_ch][tap];
    assign mac_sum   = acc + product;

    assign out_valid = (state == OUT);
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A config write in IDLE wins over sample acceptance for that cycle.
    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        unique case (state)
            IDLE: begin
                if (!cfg_we) begin
                    in_ready = gnt;
                    if (|in_valid) state_nxt = MAC;
                end
            end
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            cur_ch   <= '0;
            tap      <= '0;
            acc      <= '0;
            out_data <= '0;
            out_ch   <= '0;
            line     <= '{default: '0};
            for (int unsigned k = 0; k < ORDER; k++) begin
                coeff[TW'(k)] <= DATA_W'(default_coeff(k));
            end
        end else begin
            if (cfg_write && (32'(cfg_addr) < ORDER)) coeff[cfg_addr] <= cfg_data;

            // Only the granted channel's delay line shifts.
            if (accept) begin
                cur_ch                 <= gnt_idx;
                acc                    <= '0;
                tap                    <= '0;
                line[gnt_idx][TW'(0)]  <= in_data[32'(gnt_idx)*DATA_W +: DATA_W];
                for (int unsigned k = 1; k < ORDER; k++) begin
                    line[gnt_idx][TW'(k)] <= line[gnt_idx][TW'(k - 1)];
                end
            end

            if (state == MAC) begin
                acc <= mac_sum;
                tap <= last_tap ? '0 : tap + TW'(1);
                if (last_tap) begin
                    out_data <= mac_sum;
                    out_ch   <= cur_ch;
                end
            end

            if ((state == OUT) && out_ready) begin
                rr_ptr <= (cur_ch == CW'(CHANNELS - 1)) ? '0 : cur_ch + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Randomized self-checking bench for fir_tdm_scheduler against a convolution model.
module tb_fir_tdm_scheduler;

    localparam int CH  = 4;
    localparam int ORD = 10;
    localparam int DW  = 32;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [CH-1:0]    in_valid  = '0;
    logic [CH*DW-1:0] in_data   = '0;
    logic [CH-1:0]    in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_ch;
    logic             out_ready = 1'b1;
    logic             cfg_we    = 1'b0;
    logic [3:0]       cfg_addr  = '0;
    logic [DW-1:0]    cfg_data  = '0;
    logic             cfg_ready;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    int m_coeff [ORD];
    int m_hist  [CH][ORD];

    always #5 clk = ~clk;

    fir_tdm_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .busy      (busy)
    );

    task automatic model_reset();
        m_coeff = '{10, 3, 2, 1, -3, 1, -3, -5, 6, 6};
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < ORD; k++) m_hist[c][k] = 0;
    endtask

    // Direct-form convolution over the channel's own history, wrapping in 32 bits.
    function automatic int model_push(input int c, input int x);
        int s;
        for (int k = ORD - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = x;
        s = 0;
        for (int k = 0; k < ORD; k++) s = s + m_coeff[k] * m_hist[c][k];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; cfg_we = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Hold a sample on channel c until the handshake edge has passed.
    task automatic start_sample(input int c, input logic [DW-1:0] x, output bit ok);
        in_data[c*DW +: DW] = x;
        in_valid[c] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (in_ready[c]) ok = 1'b1;
            tick();
        end
        in_valid[c] = 1'b0;
    endtask

    // Wait for out_valid; n counts cycles since the handshake edge.
    task automatic wait_result(output int n, output logic [DW-1:0] y, output logic [1:0] ch, output bit ok);
        n = 1; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else begin tick(); n++; end
        end
        y = out_data; ch = out_ch;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (in_ready !== 4'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        vectors++; if (out_ch !== 2'd0) begin miscompares++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_impulse();
        int n, e; logic [DW-1:0] y; logic [1:0] ch; bit ok, ok2;
        do_reset();
        for (int i = 0; i <= ORD; i++) begin
            e = model_push(0, (i == 0) ? 1 : 0);
            start_sample(0, (i == 0) ? 32'd1 : 32'd0, ok);
            wait_result(n, y, ch, ok2);
            vectors++; if (!(ok && ok2)) begin miscompares++; $display("FAIL impulse_timeout step=%0d accept=%b result=%b", i, ok, ok2); end
            vectors++; if (y !== 32'(e)) begin miscompares++; $display("FAIL impulse_data step=%0d got=%0d exp=%0d", i, $signed(y), e); end
            vectors++; if (ch !== 2'd0) begin miscompares++; $display("FAIL impulse_ch step=%0d got=%0d exp=0", i, ch); end
            vectors++; if (n !== ORD + 1) begin miscompares++; $display("FAIL impulse_latency step=%0d got=%0d exp=%0d", i, n, ORD + 1); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int exp_g, g, served, got;
        bit granted;
        int expq[$]; int chq[$];
        do_reset();
        for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = $urandom;
        in_valid = '1;
        exp_g = 0; served = 0; got = 0; g = 0;
        for (int cyc = 0; cyc < 400 && got < 12; cyc++) begin
            #1;
            granted = 1'b0;
            vectors++; if ($countones(in_ready) > 1) begin miscompares++; $display("FAIL rr_onehot got=%b exp=at most one bit", in_ready); end
            if (in_ready != '0 && served < 12) begin
                for (int i = 0; i < CH; i++) if (in_ready[i]) g = i;
                vectors++; if (g !== exp_g) begin miscompares++; $display("FAIL rr_grant got=%0d exp=%0d", g, exp_g); end
                expq.push_back(model_push(g, int'(in_data[g*DW +: DW])));
                chq.push_back(g);
                exp_g = (g + 1) % CH; served++; granted = 1'b1;
            end
            if (out_valid) begin
                vectors++;
                if (expq.size() == 0) begin miscompares++; $display("FAIL rr_unexpected_out got=%h exp=none", out_data); end
                else begin
                    int e, ec;
                    e = expq.pop_front(); ec = chq.pop_front();
                    if (out_data !== 32'(e) || out_ch !== 2'(ec)) begin
                        miscompares++;
                        $display("FAIL rr_result got=%h/ch%0d exp=%h/ch%0d", out_data, out_ch, 32'(e), ec);
                    end
                end
                got++;
            end
            tick();
            if (granted) in_data[g*DW +: DW] = $urandom;
            if (served == 12) in_valid = '0;
        end
        vectors++; if (got < 12) begin miscompares++; $display("FAIL rr_timeout got=%0d exp=12 results", got); end
    endtask

    task automatic test_stall();
        int n, e, e2; logic [DW-1:0] y, x, d; logic [1:0] ch; bit ok, ok2;
        do_reset();
        out_ready = 1'b0;
        x = $urandom;
        e = model_push(3, int'(x));
        start_sample(3, x, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2)) begin miscompares++; $display("FAIL stall_timeout accept=%b result=%b exp=1/1", ok, ok2); end
        d = $urandom;
        in_data[1*DW +: DW] = d;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'(e) || out_ch !== 2'd3 || in_ready !== 4'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h ch=%0d rdy=%b busy=%b exp v=1 d=%h ch=3 rdy=0000 busy=1",
                         i, out_valid, out_data, out_ch, in_ready, busy, 32'(e));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        e2 = model_push(1, int'(d));
        start_sample(1, d, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e2) || ch !== 2'd1) begin
            miscompares++; $display("FAIL stall_release got=%h/ch%0d exp=%h/ch1", y, ch, 32'(e2));
        end
        tick();
    endtask

    task automatic test_config();
        int n, e; logic [DW-1:0] y, x; logic [1:0] ch; bit ok, ok2;
        do_reset();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = -32'sd7;
        in_data[0 +: DW] = 32'd1; in_valid[0] = 1'b1;
        #1;
        vectors++; if (in_ready !== 4'b0) begin miscompares++; $display("FAIL cfg_priority in_ready got=%b exp=0000", in_ready); end
        tick();
        cfg_we = 1'b0;
        m_coeff[0] = -7;
        e = model_push(0, 1);
        start_sample(0, 32'd1, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e)) begin miscompares++; $display("FAIL cfg_first_tap got=%0d exp=%0d", $signed(y), e); end
        tick();
        // out-of-range address is ignored
        cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 32'd555;
        tick();
        cfg_we = 1'b0;
        x = $urandom;
        e = model_push(0, int'(x));
        start_sample(0, x, ok);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 32'd99;
        #1;
        vectors++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL cfg_mac_ready got=%b/%b exp=0/1", cfg_ready, busy); end
        tick(); tick();
        cfg_we = 1'b0;
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e)) begin miscompares++; $display("FAIL cfg_mac_result got=%h exp=%h", y, 32'(e)); end
        tick();
        x = $urandom;
        e = model_push(0, int'(x));
        start_sample(0, x, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e)) begin miscompares++; $display("FAIL cfg_dropped_write got=%h exp=%h", y, 32'(e)); end
        tick();
    endtask

    task automatic test_wrap_and_midreset();
        int n, e; logic [DW-1:0] y; logic [1:0] ch; bit ok, ok2, seen;
        do_reset();
        e = model_push(1, 32'h7FFF_FFFF);
        start_sample(1, 32'h7FFF_FFFF, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e) || y !== 32'hFFFF_FFF6) begin miscompares++; $display("FAIL wrap_first got=%h exp=fffffff6", y); end
        tick();
        e = model_push(1, 32'h7FFF_FFFF);
        start_sample(1, 32'h7FFF_FFFF, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e) || y !== 32'h7FFF_FFF3) begin miscompares++; $display("FAIL wrap_second got=%h exp=7ffffff3", y); end
        tick();
        start_sample(2, $urandom, ok);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid got=%b exp=0", seen); end
        e = model_push(2, 1);
        start_sample(2, 32'd1, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e) || ch !== 2'd2) begin miscompares++; $display("FAIL midreset_impulse got=%0d/ch%0d exp=%0d/ch2", $signed(y), ch, e); end
        tick();
        e = model_push(1, 0);
        start_sample(1, 32'd0, ok);
        wait_result(n, y, ch, ok2);
        vectors++; if (!(ok && ok2) || y !== 32'(e)) begin miscompares++; $display("FAIL midreset_zeroed_line got=%h exp=%h", y, 32'(e)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_round_robin();
        test_stall();
        test_config();
        test_wrap_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
